clock_time_counter: RTL and testbench

Timekeeping core of the digital clock, directly downstream of `frequency_divider`. Samples the divider's `one_hz_clk` in the `clk` domain and detects its rising edges. Advances a BCD hours:minutes:seconds count once per edge. Provides a SET mode for adjusting minutes and hours from debounced button pulses. Outputs feed the display-scan stage.

---
 rtl/clock_time_counter.sv | 141 ++++++++++++++
 tb/tb_clock_time_counter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_counter.sv
// BCD hh:mm:ss timekeeper advanced by a synchronised 1 Hz strobe, with a SET mode for adjustment.
// Define CLOCK_12H_EN for 12-hour counting with an AM/PM flag; default build counts 24 hours.
module clock_time_counter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_hz_clk,
  input  logic       set_en,
  input  logic       inc_min,
  input  logic       inc_hour,
  input  logic       clr_sec,
  output logic [7:0] hour,
  output logic [7:0] min,
  output logic [7:0] sec,
  output logic       tick,
  output logic       pm
);

`ifdef CLOCK_12H_EN
  localparam bit         HOUR_12    = 1'b1;
  localparam logic [7:0] HOUR_RST   = 8'h12;
  localparam logic [7:0] HOUR_LAST  = 8'h12;
  localparam logic [7:0] HOUR_FIRST = 8'h01;
`else
  localparam bit         HOUR_12    = 1'b0;
  localparam logic [7:0] HOUR_RST   = 8'h00;
  localparam logic [7:0] HOUR_LAST  = 8'h23;
  localparam logic [7:0] HOUR_FIRST = 8'h00;
`endif

  typedef enum logic {MODE_RUN, MODE_SET} mode_e;

  // Seconds/minutes: units wrap 9->0 into tens, 59 wraps to 00.
  function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] != 4'd9)      r = {v[7:4], v[3:0] + 4'd1};
    else if (v[7:4] == 4'd5) r = 8'h00;
    else                     r = {v[7:4] + 4'd1, 4'd0};
    return r;
  endfunction

  function automatic logic [7:0] hour_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == HOUR_LAST)      r = HOUR_FIRST;
    else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                     r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q;
  mode_e                  mode_q, mode_d;
  logic                   inc_min_q, inc_min_prev_q;
  logic                   inc_hour_q, inc_hour_prev_q;
  logic [7:0]             hour_q, hour_d;
  logic [7:0]             min_q, min_d;
  logic [7:0]             sec_q, sec_d;
  logic                   tick_q, tick_d;
  logic                   pm_q, pm_d;
  logic                   rise, min_edge, hour_edge;

  if (SYNC_STAGES == 1) begin : g_sync_one
    assign sync_d = one_hz_clk;
  end else begin : g_sync_many
    assign sync_d = {sync_q[SYNC_STAGES-2:0], one_hz_clk};
  end

  assign rise      = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign min_edge  = inc_min_q & ~inc_min_prev_q;
  assign hour_edge = inc_hour_q & ~inc_hour_prev_q;
  assign mode_d    = set_en ? MODE_SET : MODE_RUN;

  always_comb begin
    // NOTE: every next-state value gets a default first so no path infers a latch.
    hour_d = hour_q;
    min_d  = min_q;
    sec_d  = sec_q;
    pm_d   = pm_q;
    tick_d = 1'b0;
    if (mode_q == MODE_RUN) begin
      if (rise) begin
        tick_d = 1'b1;
        sec_d  = bcd_inc60(sec_q);
        if (sec_q == 8'h59) begin
          min_d = bcd_inc60(min_q);
          if (min_q == 8'h59) begin
            hour_d = hour_inc(hour_q);
            if (HOUR_12 && hour_q == 8'h11) pm_d = ~pm_q;
          end
        end
      end
    end else begin
      // SET mode: a pending second is dropped; minutes never carry into hours.
      if (min_edge) min_d = bcd_inc60(min_q);
      if (hour_edge) begin
        hour_d = hour_inc(hour_q);
        if (HOUR_12 && hour_q == 8'h11) pm_d = ~pm_q;
      end
      if (clr_sec) sec_d = 8'h00;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q          <= '0;
      prev_q          <= 1'b0;
      mode_q          <= MODE_RUN;
      inc_min_q       <= 1'b0;
      inc_min_prev_q  <= 1'b0;
      inc_hour_q      <= 1'b0;
      inc_hour_prev_q <= 1'b0;
      hour_q          <= HOUR_RST;
      min_q           <= 8'h00;
      sec_q           <= 8'h00;
      tick_q          <= 1'b0;
      pm_q            <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      sync_q          <= sync_d;
      prev_q          <= sync_q[SYNC_STAGES-1];
      mode_q          <= mode_d;
      inc_min_q       <= inc_min;
      inc_min_prev_q  <= inc_min_q;
      inc_hour_q      <= inc_hour;
      inc_hour_prev_q <= inc_hour_q;
      hour_q          <= hour_d;
      min_q           <= min_d;
      sec_q           <= sec_d;
      tick_q          <= tick_d;
      pm_q            <= pm_d;
    end
  end

  assign hour = hour_q;
  assign min  = min_q;
  assign sec  = sec_q;
  assign tick = tick_q;
  assign pm   = HOUR_12 ? pm_q : 1'b0;

endmodule

// File: tb/tb_clock_time_counter.sv
// Directed bench for clock_time_counter: a time-of-day model in integers checked every cycle,
// plus literal expectations at key points. Honours CLOCK_12H_EN when the build defines it.
module tb_clock_time_counter;
  localparam int S = 2;

`ifdef CLOCK_12H_EN
  localparam bit H12   = 1'b1;
  localparam int H_RST = 12;
`else
  localparam bit H12   = 1'b0;
  localparam int H_RST = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       one_hz_clk = 1'b0;
  logic       set_en = 1'b0;
  logic       inc_min = 1'b0;
  logic       inc_hour = 1'b0;
  logic       clr_sec = 1'b0;
  logic [7:0] hour, min, sec;
  logic       tick, pm;

  int n_vec = 0;
  int n_miss = 0;

  clock_time_counter #(.SYNC_STAGES(S)) dut (
    .clk        (clk),
    .reset      (reset),
    .one_hz_clk (one_hz_clk),
    .set_en     (set_en),
    .inc_min    (inc_min),
    .inc_hour   (inc_hour),
    .clr_sec    (clr_sec),
    .hour       (hour),
    .min        (min),
    .sec        (sec),
    .tick       (tick),
    .pm         (pm)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  // ---------------- time-of-day model ----------------
  int m_h = H_RST;
  int m_m = 0;
  int m_s = 0;
  bit m_pm = 1'b0;
  bit m_tick = 1'b0;
  // Input samples taken at previous edges: index 0 is one edge ago.
  bit oh_hist [0:S];
  bit set_hist = 1'b0;
  bit im_hist [0:1];
  bit ih_hist [0:1];

  task automatic step_hour();
    if (H12) begin
      if (m_h == 11) m_pm = !m_pm;
      m_h = (m_h == 12) ? 1 : m_h + 1;
    end else begin
      m_h = (m_h + 1) % 24;
    end
  endtask

  initial begin
    bit adv, run;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_h = H_RST; m_m = 0; m_s = 0; m_pm = 1'b0; m_tick = 1'b0;
        for (int k = 0; k <= S; k++) oh_hist[k] = 1'b0;
        set_hist = 1'b0;
        im_hist[0] = 1'b0; im_hist[1] = 1'b0;
        ih_hist[0] = 1'b0; ih_hist[1] = 1'b0;
      end else begin
        // A 1 Hz rising edge sampled S edges ago advances time now, if RUN was selected last edge.
        adv    = oh_hist[S-1] && !oh_hist[S];
        run    = !set_hist;
        m_tick = run && adv;
        if (run) begin
          if (adv) begin
            m_s++;
            if (m_s == 60) begin
              m_s = 0;
              m_m++;
              if (m_m == 60) begin
                m_m = 0;
                step_hour();
              end
            end
          end
        end else begin
          if (im_hist[0] && !im_hist[1]) m_m = (m_m + 1) % 60;
          if (ih_hist[0] && !ih_hist[1]) step_hour();
          if (clr_sec) m_s = 0;
        end
        for (int k = S; k > 0; k--) oh_hist[k] = oh_hist[k-1];
        oh_hist[0] = one_hz_clk;
        set_hist   = set_en;
        im_hist[1] = im_hist[0]; im_hist[0] = inc_min;
        ih_hist[1] = ih_hist[0]; ih_hist[0] = inc_hour;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("model_hour", {24'd0, hour}, {24'd0, to_bcd(m_h)});
      check("model_min",  {24'd0, min},  {24'd0, to_bcd(m_m)});
      check("model_sec",  {24'd0, sec},  {24'd0, to_bcd(m_s)});
      check("model_tick", {31'd0, tick}, {31'd0, m_tick});
      check("model_pm",   {31'd0, pm},   {31'd0, m_pm});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic one_tick();
    one_hz_clk = 1'b1; wait_cyc(2);
    one_hz_clk = 1'b0; wait_cyc(2);
  endtask

  task automatic ticks(input int n);
    repeat (n) one_tick();
  endtask

  task automatic pulse_min(input int n);
    repeat (n) begin
      inc_min = 1'b1; wait_cyc(1);
      inc_min = 1'b0; wait_cyc(1);
    end
  endtask

  task automatic pulse_hour(input int n);
    repeat (n) begin
      inc_hour = 1'b1; wait_cyc(1);
      inc_hour = 1'b0; wait_cyc(1);
    end
  endtask

  task automatic enter_set();
    set_en = 1'b1; wait_cyc(2);
  endtask

  task automatic leave_set();
    set_en = 1'b0; wait_cyc(2);
  endtask

  task automatic check_time(input string name, input logic [7:0] h, input logic [7:0] m,
                            input logic [7:0] s);
    check({name, "_hour"}, {24'd0, hour}, {24'd0, h});
    check({name, "_min"},  {24'd0, min},  {24'd0, m});
    check({name, "_sec"},  {24'd0, sec},  {24'd0, s});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    wait_cyc(3);
`ifdef CLOCK_12H_EN
    check_time("rst12", 8'h12, 8'h00, 8'h00);
    check("rst12_pm", {31'd0, pm}, 32'd0);
    reset = 1'b0; wait_cyc(2);

    enter_set();
    pulse_hour(11);
    pulse_min(59);
    leave_set();
    ticks(59);
    check_time("pre_noon", 8'h11, 8'h59, 8'h59);
    check("pre_noon_pm", {31'd0, pm}, 32'd0);
    one_tick();
    check_time("noon", 8'h12, 8'h00, 8'h00);
    check("noon_pm", {31'd0, pm}, 32'd1);
    ticks(3600);
    check_time("one_pm", 8'h01, 8'h00, 8'h00);
    check("one_pm_pm", {31'd0, pm}, 32'd1);
`else
    check_time("rst", 8'h00, 8'h00, 8'h00);
    check("rst_tick", {31'd0, tick}, 32'd0);
    check("rst_pm", {31'd0, pm}, 32'd0);
    reset = 1'b0; wait_cyc(2);

    // Latency: rise sampled at edge 1 shows up at edge S+1 = 3, then nothing more.
    one_hz_clk = 1'b1;
    wait_cyc(1); check("lat_e1_sec", {24'd0, sec}, 32'h00);
    wait_cyc(1); check("lat_e2_sec", {24'd0, sec}, 32'h00);
    check("lat_e2_tick", {31'd0, tick}, 32'd0);
    wait_cyc(1); check("lat_e3_sec", {24'd0, sec}, 32'h01);
    check("lat_e3_tick", {31'd0, tick}, 32'd1);
    wait_cyc(1); check("lat_e4_tick", {31'd0, tick}, 32'd0);
    wait_cyc(46); check("lat_hold_sec", {24'd0, sec}, 32'h01);
    one_hz_clk = 1'b0; wait_cyc(3);

    // Rollover through midnight.
    enter_set();
    pulse_hour(23);
    pulse_min(59);
    clr_sec = 1'b1; wait_cyc(2); clr_sec = 1'b0;
    leave_set();
    check_time("set_2359", 8'h23, 8'h59, 8'h00);
    ticks(59);
    check_time("pre_midnight", 8'h23, 8'h59, 8'h59);
    one_tick();
    check_time("midnight", 8'h00, 8'h00, 8'h00);

    // SET behaviour: min wraps without carry, seconds frozen, simultaneous increments.
    ticks(7);
    enter_set();
    pulse_hour(5);
    pulse_min(59);
    check_time("set_0559", 8'h05, 8'h59, 8'h07);
    pulse_min(1);
    check_time("min_wrap", 8'h05, 8'h00, 8'h07);
    ticks(3);
    check("set_frozen_sec", {24'd0, sec}, 32'h07);
    inc_min = 1'b1; inc_hour = 1'b1; wait_cyc(1);
    inc_min = 1'b0; inc_hour = 1'b0; wait_cyc(1);
    check_time("both_inc", 8'h06, 8'h01, 8'h07);
    clr_sec = 1'b1; wait_cyc(3);
    check("clr_sec", {24'd0, sec}, 32'h00);
    clr_sec = 1'b0;
    pulse_hour(18);
    check("hour_wrap", {24'd0, hour}, 32'h00);
    leave_set();

    // Level held across a mode change must not look like a new press.
    inc_min = 1'b1; wait_cyc(3);
    check("run_ignores_inc", {24'd0, min}, 32'h01);
    set_en = 1'b1; wait_cyc(4);
    check("no_phantom_edge", {24'd0, min}, 32'h01);
    inc_min = 1'b0; wait_cyc(2);
    leave_set();

    // Asynchronous reset mid-count.
    reset = 1'b1; wait_cyc(1); reset = 1'b0; wait_cyc(2);
    enter_set();
    pulse_min(5);
    leave_set();
    ticks(30);
    check_time("pre_reset", 8'h00, 8'h05, 8'h30);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check_time("async_rst", 8'h00, 8'h00, 8'h00);
    check("async_rst_tick", {31'd0, tick}, 32'd0);
    wait_cyc(2);
    reset = 1'b0; wait_cyc(2);
    one_tick();
    check_time("post_reset", 8'h00, 8'h00, 8'h01);
`endif
    wait_cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
